dcache_direct_wb: RTL
=====================

Name: dcache_direct_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits directly downstream of the pipeline's D_cache interface (DCACHE_ren/wen/addr/wdata/stall/rdata) and upstream of slow main memory.
- Serves single-cycle hits; raises stall on misses while it writes back a dirty victim line and/or fetches the requested line.
- Data is stored exactly as presented by the core; no byte swapping inside the block.

Parameters:
- INDEX_W, 3, index width; number of lines = 2**INDEX_W.
- TAG_W, 25, tag width; must equal 28 - INDEX_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- proc_read  input  1  core load request (DCACHE_ren).
- proc_write  input  1  core store request (DCACHE_wen).
- proc_addr  input  30  word address (DCACHE_addr).
- proc_wdata  input  32  store data.
- proc_stall  output  1  high while the request cannot complete this cycle.
- proc_rdata  output  32  load data; valid when proc_read=1 and proc_stall=0.
- mem_read  output  1  line fetch request.
- mem_write  output  1  line write-back request.
- mem_addr  output  28  line address (word address [29:2]).
- mem_wdata  output  128  victim line; word k at bits [32k+31:32k].
- mem_rdata  input  128  fetched line, same word ordering.
- mem_ready  input  1  one-cycle pulse: transfer complete.

Behaviour:
- Address split: offset = proc_addr[1:0]; index = proc_addr[INDEX_W+1:2]; tag = proc_addr[29:INDEX_W+2].
- Per line state: valid, dirty, tag, 128-bit data.
- hit = valid[index] & (tag_store[index] == tag).
- Reset (async, rst_n=0): all valid and dirty cleared, state=IDLE; proc_stall=0, proc_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. A reset mid-transfer abandons it immediately; data and tag arrays need not be cleared.
- Request = proc_read | proc_write. If both are high, the access is a write: the store is performed and proc_rdata is don't-care.
- FSM state IDLE:
  - No request: proc_stall=0; state unchanged.
  - Request and hit: proc_stall=0 combinationally in the same cycle.
    - Read: proc_rdata = line word[offset] combinationally.
    - Write: on the clock edge, word[offset] <= proc_wdata and dirty[index] <= 1.
  - Request and miss: proc_stall=1 combinationally.
    - If valid[index] & dirty[index]: next state = WRITEBACK.
    - Otherwise: next state = ALLOCATE.
- FSM state WRITEBACK:
  - Outputs: proc_stall=1, mem_write=1, mem_addr = {tag_store[index], index}, mem_wdata = stored line.
  - On mem_ready: next state = ALLOCATE, and dirty[index] <= 0.
- FSM state ALLOCATE:
  - Outputs: proc_stall=1, mem_read=1, mem_addr = proc_addr[29:2].
  - On mem_ready, at that edge: line <= mem_rdata, tag_store <= tag, valid <= 1, dirty <= 0; next state = IDLE.
  - The next cycle in IDLE is a hit and completes the access. Miss cost = mem latency + 1 cycle (clean) or 2x mem latency + 1 cycle (dirty).
- mem_read and mem_write are never high together. Both are registered state decodes, low in the cycle after mem_ready.
- The core holds proc_read/proc_write/proc_addr/proc_wdata stable while proc_stall=1; the cache does not latch them.
- mem_ready outside WRITEBACK/ALLOCATE is ignored.
- mem_ready held high for multiple cycles: each high cycle is treated as a completion (memory contract forbids it).
- Stores on a miss are applied only after allocation (write-allocate); memory never receives partial words.

Test Plan:
- Reset, then read addr 0x00000010 with no preceding access -> proc_stall=1 same cycle, mem_read=1 with mem_addr=0x0000004. Memory returns 0x44444444_33333333_22222222_11111111 after 3 cycles -> next cycle proc_stall=0, proc_rdata=0x11111111.
- Read 0x00000011 right after the previous test -> hit, proc_stall=0 in the same cycle, proc_rdata=0x22222222, mem_read stays 0.
- Write 0xDEADBEEF to 0x00000012 (hit) -> no stall, dirty set. Then read 0x00000032 (same index 4, different tag) -> WRITEBACK with mem_write=1, mem_addr=0x0000004, mem_wdata word2=0xDEADBEEF. After mem_ready -> ALLOCATE with mem_addr=0x000000C, then hit.
- Write miss to clean line at 0x00000100 -> ALLOCATE only (no mem_write). After fill, word0 = proc_wdata and the line is dirty; a later conflicting access to index 0 triggers a write-back containing that word.
- Assert rst_n=0 during ALLOCATE, before mem_ready -> mem_read=0 and proc_stall=0 immediately. After release, the same read misses again (valid cleared).
- proc_read=proc_write=1 on a hit to 0x00000011 with wdata 0x0BADF00D -> no stall; a subsequent read of 0x00000011 returns 0x0BADF00D.

Source files
------------

// File: rtl/dcache_direct_wb.sv
// Direct-mapped, write-back, write-allocate data cache.
// Single-cycle hits; stalls the core across victim write-back and line fill.
`timescale 1ns/1ps
module dcache_direct_wb #(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);
  localparam int LINES = 2**INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [127:0]     data_q [LINES];

  logic [1:0]         off;
  logic [6:0]         off_bit;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [127:0]       line;
  logic [127:0]       line_wr;
  logic               req;
  logic               hit;
  logic               wr_hit;
  logic               wb_done;
  logic               fill;

  assign off     = proc_addr[1:0];
  assign off_bit = {off, 5'b0};
  assign idx     = proc_addr[INDEX_W+1:2];
  assign tag     = proc_addr[29:INDEX_W+2];
  assign line    = data_q[idx];
  assign req     = proc_read | proc_write;
  assign hit     = valid_q[idx] & (tag_q[idx] == tag);
  assign wb_done = (state_q == WRITEBACK) & mem_ready;
  assign fill    = (state_q == ALLOCATE) & mem_ready;

  always_comb begin
    line_wr = line;
    line_wr[off_bit +: 32] = proc_wdata;
  end

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_hit     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && hit) begin
          wr_hit = proc_write;
          if (!proc_write) proc_rdata = line[off_bit +: 32];
        end else if (req) begin
          proc_stall = 1'b1;
          state_d = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[idx], idx};
        mem_wdata  = line;
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[29:2];
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Core sees a quiet cache for the whole reset window, even mid-request.
    if (!rst_n) begin
      proc_stall = 1'b0;
      proc_rdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (wr_hit) dirty_q[idx] <= 1'b1;
      if (wb_done) dirty_q[idx] <= 1'b0;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      data_q[idx] <= mem_rdata;
      tag_q[idx]  <= tag;
    end else if (wr_hit) begin
      data_q[idx] <= line_wr;
    end
  end

endmodule
